// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the byte-wide instruction memory port between the
// CPU fetch path (32-bit little-endian reads) and the program loader (32-bit
// writes). Each word is serialised into four byte accesses on consecutive
// addresses.
// Optional feature: define IMEM_ARB_RR_EN for round-robin arbitration;
// otherwise the loader has fixed priority over fetch.
module imem_port_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_BYTES - 4);

  state_t            state, state_nx;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wbuf;
  logic [23:0]       rbuf;
  logic              is_load;
  logic              err;

  logic              grant_load, grant_fetch, accept, addr_bad;
  logic [ADDR_W-1:0] acc_addr;

`ifdef IMEM_ARB_RR_EN
  logic last_load;

  // Remember which requester won the most recent accept (errors included).
  always_ff @(posedge clk) begin
    if (rst)
      last_load <= 1'b0;
    else if (accept)
      last_load <= grant_load;
  end
`endif

  // Grant decision and range check; only meaningful while idle.
  always_comb begin
    grant_load  = 1'b0;
    grant_fetch = 1'b0;
    if (state == IDLE) begin
`ifdef IMEM_ARB_RR_EN
      if (load_req && fetch_req) begin
        grant_load  = !last_load;
        grant_fetch = last_load;
      end else begin
        grant_load  = load_req;
        grant_fetch = fetch_req;
      end
`else
      grant_load  = load_req;
      grant_fetch = fetch_req && !load_req;
`endif
    end
    accept   = grant_load || grant_fetch;
    acc_addr = grant_load ? load_addr : fetch_addr;
    addr_bad = acc_addr > MAX_BASE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and all outputs, decoded from registered state only
  // (grants excepted, which are request handshakes, not memory signals).
  always_comb begin
    state_nx    = state;
    fetch_ready = grant_fetch;
    load_ready  = grant_load;
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    load_done   = 1'b0;
    load_err    = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        if (accept)
          state_nx = addr_bad ? RESP : (grant_load ? WR : RD);
      end
      RD: begin
        mem_addr = base + ADDR_W'(cnt);
        if (cnt == 2'd3)
          state_nx = RESP;
      end
      WR: begin
        mem_addr  = base + ADDR_W'(cnt);
        mem_we    = 1'b1;
        mem_wdata = wbuf[{cnt, 3'b000} +: 8];
        if (cnt == 2'd3)
          state_nx = RESP;
      end
      RESP: begin
        fetch_valid = !is_load;
        fetch_err   = !is_load && err;
        load_done   = is_load;
        load_err    = is_load && err;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latches, byte counter and read-word assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      base       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
      is_load    <= 1'b0;
      err        <= 1'b0;
      fetch_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            base    <= acc_addr;
            wbuf    <= load_data;
            is_load <= grant_load;
            err     <= addr_bad;
            if (grant_fetch && addr_bad)
              fetch_data <= '0;
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          // Bytes gather in rbuf so fetch_data only changes when the word completes.
          case (cnt)
            2'd0:    rbuf[7:0]   <= mem_rdata;
            2'd1:    rbuf[15:8]  <= mem_rdata;
            2'd2:    rbuf[23:16] <= mem_rdata;
            default: fetch_data  <= {mem_rdata, rbuf};
          endcase
        end
        WR: cnt <= cnt + 2'd1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: table-driven word transactions against a
// byte-array memory model, plus hand-written reset-abort and arbitration
// sequences.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_ready, fetch_valid, fetch_err;
  logic [63:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        load_req, load_ready, load_done, load_err;
  logic [63:0] load_addr;
  logic [31:0] load_data;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [0:511];
  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [7:0]  bd_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(64), .MEM_BYTES(512)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .load_err(load_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: DUT byte writes plus a bench backdoor for presetting contents.
  always @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (mem_we && mem_addr < 64'd512)
      mem[mem_addr[8:0]] <= mem_wdata;
  end

  always_comb mem_rdata = (mem_addr < 64'd512) ? mem[mem_addr[8:0]] : 8'h00;

  typedef struct {
    logic        is_load;
    logic [63:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 9'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int cyc, nwe, bad, k;
    logic seen;
    @(negedge clk);
    if (v.is_load) begin
      load_req = 1'b1; load_addr = v.addr; load_data = v.data;
    end else begin
      fetch_req = 1'b1; fetch_addr = v.addr;
    end
    #1;
    chk($sformatf("ready%0d", idx), v.is_load ? load_ready : fetch_ready, 1);
    @(posedge clk); #1;
    // Scramble inputs after accept: the DUT must use its latched copies.
    load_req = 1'b0; fetch_req = 1'b0;
    fetch_addr = 64'h1F0; load_addr = 64'h1F4; load_data = 32'hFFFF_FFFF;
    cyc = 1; nwe = 0; bad = 0; seen = 1'b0;
    while (cyc <= 20 && !seen) begin
      if (v.is_load ? load_done : fetch_valid) seen = 1'b1;
      else begin
        k = cyc - 1;
        if (mem_we) nwe++;
        if (!v.exp_err && k < 4) begin
          if (mem_addr !== v.addr + 64'(k)) bad++;
          if (mem_we !== v.is_load) bad++;
          if (v.is_load && mem_wdata !== v.data[8*k +: 8]) bad++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk($sformatf("latency%0d", idx), 64'(cyc), v.exp_err ? 1 : 5);
    chk($sformatf("we_cycles%0d", idx), 64'(nwe), (v.is_load && !v.exp_err) ? 4 : 0);
    chk($sformatf("bus_seq%0d", idx), 64'(bad), 0);
    chk($sformatf("err%0d", idx), v.is_load ? load_err : fetch_err, v.exp_err);
    chk($sformatf("other_pulse%0d", idx), v.is_load ? fetch_valid : load_done, 0);
    if (!v.is_load) chk($sformatf("fetch_data%0d", idx), fetch_data, v.exp_data);
    @(posedge clk); #1;
    chk($sformatf("pulse_len%0d", idx), v.is_load ? load_done : fetch_valid, 0);
  endtask

  initial begin
    int nacc, both, ncyc;
    logic got_load [4];
    logic exp_load [4];

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0; load_addr = '0; load_data = '0;

    vt[0] = '{1'b0, 64'h10,  32'h0,         32'h4433_2211, 1'b0};
    vt[1] = '{1'b1, 64'h20,  32'hDEAD_BEEF, 32'h0,         1'b0};
    vt[2] = '{1'b0, 64'h20,  32'h0,         32'hDEAD_BEEF, 1'b0};
    vt[3] = '{1'b0, 64'd509, 32'h0,         32'h0,         1'b1};
    vt[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h1234_5678, 32'h0, 1'b1};
    vt[5] = '{1'b1, 64'd508, 32'hA1B2_C3D4, 32'h0,         1'b0};
    vt[6] = '{1'b0, 64'd508, 32'h0,         32'hA1B2_C3D4, 1'b0};
    vt[7] = '{1'b1, 64'h0,   32'h0102_0304, 32'h0,         1'b0};
    vt[8] = '{1'b0, 64'h0,   32'h0,         32'h0102_0304, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_ready_idle", {fetch_ready, load_ready}, 0);

    poke(16'h10, 8'h11); poke(16'h11, 8'h22); poke(16'h12, 8'h33); poke(16'h13, 8'h44);

    for (int i = 0; i < 9; i++) run_txn(vt[i], i);

    // Reset during the second WR cycle of a load to 0x30.
    for (int a = 48; a < 52; a++) poke(a, 8'h55);
    @(negedge clk);
    load_req = 1'b1; load_addr = 64'h30; load_data = 32'h4433_2211;
    @(posedge clk); #1;
    load_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_wr2_addr", mem_addr, 64'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_we_low", mem_we, 0);
    chk("abort_addr_zero", mem_addr, 0);
    ncyc = 0;
    for (int c = 0; c < 8; c++) begin
      if (load_done) ncyc++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(ncyc), 0);
    chk("abort_b30", mem[48], 8'h11);
    chk("abort_b31", mem[49], 8'h22);
    chk("abort_b32", mem[50], 8'h55);
    chk("abort_b33", mem[51], 8'h55);

    // Both requesters held continuously; last grant is fetch after the reset.
`ifdef IMEM_ARB_RR_EN
    exp_load = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_load = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    load_req = 1'b1; load_addr = 64'h40; load_data = 32'h0A0B_0C0D;
    fetch_req = 1'b1; fetch_addr = 64'h10;
    nacc = 0; both = 0; ncyc = 0;
    while (nacc < 4 && ncyc < 60) begin
      #1;
      if (fetch_ready && load_ready) both++;
      if (fetch_ready || load_ready) begin
        got_load[nacc] = load_ready;
        nacc++;
      end
      @(negedge clk);
      ncyc++;
    end
    load_req = 1'b0; fetch_req = 1'b0;
    chk("arb_accepts", 64'(nacc), 4);
    chk("arb_one_ready", 64'(both), 0);
    for (int i = 0; i < 4; i++)
      if (i < nacc) chk($sformatf("arb_grant%0d", i), got_load[i], exp_load[i]);
    repeat (8) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
